// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and parameter-legality check for the pipelined CLA adder.
package pipelined_cla_adder_pkg;

    localparam int CLA_GROUP_W = 4;

    // True when WIDTH splits into whole 4-bit groups and those groups split
    // evenly across the pipeline stages.
    function automatic bit cla_params_ok(input int width, input int stages);
        if (width < CLA_GROUP_W || (width % CLA_GROUP_W) != 0) return 1'b0;
        if (stages < 1) return 1'b0;
        return ((width / CLA_GROUP_W) % stages) == 0;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla4.sv
// One 4-bit carry-lookahead group: local carries, group generate/propagate.
module cla4_group
    import pipelined_cla_adder_pkg::*;
(
    input  logic [CLA_GROUP_W-1:0] a,
    input  logic [CLA_GROUP_W-1:0] b,
    input  logic                   cin,
    output logic [CLA_GROUP_W-1:0] sum,
    output logic                   g,
    output logic                   p,
    output logic                   cout
);

    logic [CLA_GROUP_W-1:0] gi;
    logic [CLA_GROUP_W-1:0] pi;
    logic [CLA_GROUP_W-1:0] c;

    assign gi = a & b;
    assign pi = a ^ b;

    assign c[0] = cin;
    assign c[1] = gi[0] | (pi[0] & cin);
    assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
    assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                | (pi[2] & pi[1] & pi[0] & cin);

    assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
    assign p    = &pi;
    assign cout = g | (p & cin);
    assign sum  = pi ^ c;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each stage resolves an equal slice of 4-bit groups and registers its carry.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Guarded so an illegal configuration reaches the $error below cleanly.
    localparam int NGROUPS = (WIDTH < CLA_GROUP_W) ? 1 : WIDTH / CLA_GROUP_W;
    localparam int STG     = (STAGES < 1) ? 1 : STAGES;
    localparam int GPS     = (NGROUPS / STG < 1) ? 1 : NGROUPS / STG;
    localparam int SW      = GPS * CLA_GROUP_W;

    if (!cla_params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and WIDTH/4 divisible by STAGES");
    end

    logic [WIDTH-1:0] a_q [STG];
    logic [WIDTH-1:0] b_q [STG];
    logic [WIDTH-1:0] s_q [STG];
    logic             c_q [STG];
    logic             v_q [STG];
    logic             ovf_q;
    logic             adv;

    // The whole pipe moves together; it only freezes when the output is held.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar s = 0; s < STG; s++) begin : g_stage
        localparam int LSB = s * SW;

        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] s_i;
        logic             c_i;
        logic             v_i;
        logic [GPS:0]     gc;
        logic [GPS-1:0]   gg;
        logic [GPS-1:0]   gp;
        logic [GPS-1:0]   gco;
        logic [SW-1:0]    slice_sum;
        logic [WIDTH-1:0] s_d;
        logic             unused_grp;

        if (s == 0) begin : g_head
            // Subtraction is A + ~B + 1, so the inverted B travels down the pipe.
            assign a_i = a;
            assign b_i = sub ? ~b : b;
            assign s_i = '0;
            assign c_i = sub | cin;
            assign v_i = in_valid;
        end else begin : g_body
            assign a_i = a_q[s-1];
            assign b_i = b_q[s-1];
            assign s_i = s_q[s-1];
            assign c_i = c_q[s-1];
            assign v_i = v_q[s-1];
        end

        assign gc[0] = c_i;

        for (genvar k = 0; k < GPS; k++) begin : g_grp
            cla4_group u_grp (
                .a    (a_i[LSB + k*CLA_GROUP_W +: CLA_GROUP_W]),
                .b    (b_i[LSB + k*CLA_GROUP_W +: CLA_GROUP_W]),
                .cin  (gc[k]),
                .sum  (slice_sum[k*CLA_GROUP_W +: CLA_GROUP_W]),
                .g    (gg[k]),
                .p    (gp[k]),
                .cout (gco[k])
            );
            assign gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end

        // Group couts duplicate the G/P chain; kept only for the group's own use.
        assign unused_grp = ^gco;

        // Splice this stage's slice into the sum bits completed so far.
        always_comb begin
            s_d                = s_i;
            s_d[LSB +: SW]     = slice_sum;
        end

        // Stage register: valid always advances, data only for real beats.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q[s] <= 1'b0;
                c_q[s] <= 1'b0;
                a_q[s] <= '0;
                b_q[s] <= '0;
                s_q[s] <= '0;
            end else if (adv) begin
                v_q[s] <= v_i;
                if (v_i) begin
                    a_q[s] <= a_i;
                    b_q[s] <= b_i;
                    s_q[s] <= s_d;
                    c_q[s] <= gc[GPS];
                end
            end
        end

        if (s == STG - 1) begin : g_tail
            // Carry into the MSB is recovered as a ^ b_eff ^ sum at that bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv && v_i) begin
                    ovf_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1] ^ s_d[WIDTH-1] ^ gc[GPS];
                end
            end
        end
    end

    logic unused_tail;
    assign unused_tail = ^{a_q[STG-1], b_q[STG-1]};

    assign out_valid = v_q[STG-1];
    assign sum       = s_q[STG-1];
    assign cout      = c_q[STG-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder across STAGES = 1, 2, 4, 8.
module tb_pipelined_cla_adder;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iv    [4];
    logic        ir    [4];
    logic        ov    [4];
    logic        ordy  [4];
    logic        tcin  [4];
    logic        tsub  [4];
    logic        tcout [4];
    logic        tovf  [4];
    logic [31:0] ta    [4];
    logic [31:0] tb    [4];
    logic [31:0] tsum  [4];

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(32), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(ta[0]), .b(tb[0]),
        .cin(tcin[0]), .sub(tsub[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(tsum[0]), .cout(tcout[0]), .ovf(tovf[0]));
    pipelined_cla_adder #(.WIDTH(32), .STAGES(2)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(ta[1]), .b(tb[1]),
        .cin(tcin[1]), .sub(tsub[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(tsum[1]), .cout(tcout[1]), .ovf(tovf[1]));
    pipelined_cla_adder #(.WIDTH(32), .STAGES(4)) u_s4 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(ta[2]), .b(tb[2]),
        .cin(tcin[2]), .sub(tsub[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .sum(tsum[2]), .cout(tcout[2]), .ovf(tovf[2]));
    pipelined_cla_adder #(.WIDTH(32), .STAGES(8)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a(ta[3]), .b(tb[3]),
        .cin(tcin[3]), .sub(tsub[3]), .out_valid(ov[3]), .out_ready(ordy[3]),
        .sum(tsum[3]), .cout(tcout[3]), .ovf(tovf[3]));

    // Reference: plain 33-bit arithmetic, overflow from operand/result signs.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic sb);
        exp_t        m;
        logic [31:0] yy;
        logic [32:0] r;
        yy  = sb ? ~y : y;
        r   = {1'b0, x} + {1'b0, yy} + {32'd0, (sb ? 1'b1 : ci)};
        m.s = r[31:0];
        m.c = r[32];
        m.o = (x[31] == yy[31]) && (r[31] != x[31]);
        return m;
    endfunction

    task automatic sb_push(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int d, output exp_t e, output bit ok);
        ok = 1'b1;
        e  = '0;
        case (d)
            0:       if (q0.size() == 0) ok = 1'b0; else e = q0.pop_front();
            1:       if (q1.size() == 0) ok = 1'b0; else e = q1.pop_front();
            2:       if (q2.size() == 0) ok = 1'b0; else e = q2.pop_front();
            default: if (q3.size() == 0) ok = 1'b0; else e = q3.pop_front();
        endcase
    endtask

    function automatic int sb_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (ov[d] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b want 0", d, ov[d]); end
            n_checks++;
            if (ir[d] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b want 1", d, ir[d]); end
            n_checks++;
            if ({tsum[d], tcout[d], tovf[d]} !== 34'd0) begin
                n_fail++; $display("FAIL reset_result[%0d]: got %h/%b/%b want 0/0/0", d, tsum[d], tcout[d], tovf[d]);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL reset_clocked: got %b want 0", ov[1]); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [31:0] vs [7];
        logic        vc [7];
        logic        vsb[7];
        logic        vco[7];
        logic        vov[7];
        va  = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'd5, 32'd5, 32'h12345678, 32'h0000FFFF};
        vb  = '{32'h00000001, 32'h00000001, 32'h00000001, 32'd9, 32'd9, 32'h0F0F0F0F, 32'h00000001};
        vc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vsb = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vs  = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h21436588, 32'h00010000};
        vco = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vov = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            iv[1] = 1'b1; ordy[1] = 1'b1;
            ta[1] = va[i]; tb[1] = vb[i]; tcin[1] = vc[i]; tsub[1] = vsb[i];
            #1;
            n_checks++;
            if (ir[1] !== 1'b1) begin n_fail++; $display("FAIL dir_in_ready[%0d]: got %b want 1", i, ir[1]); end
            @(negedge clk);
            iv[1] = 1'b0;
            #1;
            n_checks++;
            if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL dir_early[%0d]: got %b want 0", i, ov[1]); end
            @(negedge clk);
            #1;
            n_checks++;
            if (ov[1] !== 1'b1) begin n_fail++; $display("FAIL dir_latency[%0d]: got %b want 1", i, ov[1]); end
            n_checks++;
            if ({tsum[1], tcout[1], tovf[1]} !== {vs[i], vco[i], vov[i]}) begin
                n_fail++;
                $display("FAIL dir_result[%0d]: got %h/%b/%b want %h/%b/%b",
                         i, tsum[1], tcout[1], tovf[1], vs[i], vco[i], vov[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        int          recv = 0;
        bit          stall;
        bit          prev_stall = 1'b0;
        bit          ok;
        exp_t        e;
        logic [33:0] hold = '0;
        for (int cyc = 0; cyc < 80 && recv < 16; cyc++) begin
            @(negedge clk);
            stall   = (cyc >= 10 && cyc < 13);
            ordy[1] = !stall;
            if (sent < 16) begin
                iv[1] = 1'b1;
                ta[1] = $urandom; tb[1] = $urandom;
                tcin[1] = 1'($urandom_range(0, 1)); tsub[1] = 1'($urandom_range(0, 1));
            end else begin
                iv[1] = 1'b0;
            end
            #1;
            if (stall) begin
                n_checks++;
                if (ir[1] !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready@%0d: got %b want 0", cyc, ir[1]); end
                n_checks++;
                if (ov[1] !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid@%0d: got %b want 1", cyc, ov[1]); end
                if (prev_stall) begin
                    n_checks++;
                    if ({tsum[1], tcout[1], tovf[1]} !== hold) begin
                        n_fail++; $display("FAIL stall_hold@%0d: got %h want %h", cyc, {tsum[1], tcout[1], tovf[1]}, hold);
                    end
                end
            end
            if (ov[1] && ordy[1]) begin
                sb_pop(1, e, ok);
                n_checks++;
                if (!ok || {tsum[1], tcout[1], tovf[1]} !== e) begin
                    n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h (queued=%0d)", recv, {tsum[1], tcout[1], tovf[1]}, e, ok);
                end
                if (recv < 8) begin
                    n_checks++;
                    if (cyc != 2 + recv) begin n_fail++; $display("FAIL b2b_timing[%0d]: got cycle %0d want %0d", recv, cyc, 2 + recv); end
                end
                recv++;
            end
            if (iv[1] && ir[1]) begin
                sb_push(1, model(ta[1], tb[1], tcin[1], tsub[1]));
                sent++;
            end
            hold       = {tsum[1], tcout[1], tovf[1]};
            prev_stall = stall;
        end
        iv[1] = 1'b0; ordy[1] = 1'b1;
        n_checks++;
        if (recv != 16 || sb_size(1) != 0) begin
            n_fail++; $display("FAIL b2b_count: got %0d received, %0d pending want 16, 0", recv, sb_size(1));
        end
    endtask

    task automatic test_reset_midflight();
        exp_t e;
        @(negedge clk);
        iv[1] = 1'b1; ordy[1] = 1'b0; ta[1] = 32'h11111111; tb[1] = 32'h22222222; tcin[1] = 1'b0; tsub[1] = 1'b0;
        @(negedge clk);
        ta[1] = 32'h33333333;
        @(negedge clk);
        iv[1] = 1'b0;
        #1;
        n_checks++;
        if (ov[1] !== 1'b1) begin n_fail++; $display("FAIL midrst_inflight: got %b want 1", ov[1]); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (ov[1] !== 1'b0 || ir[1] !== 1'b1) begin
            n_fail++; $display("FAIL midrst_async: got valid %b ready %b want 0 1", ov[1], ir[1]);
        end
        n_checks++;
        if ({tsum[1], tcout[1], tovf[1]} !== 34'd0) begin
            n_fail++; $display("FAIL midrst_result: got %h want 0", {tsum[1], tcout[1], tovf[1]});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0; ordy[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL midrst_stale@%0d: got %b want 0", i, ov[1]); end
        end
        @(negedge clk);
        iv[1] = 1'b1; ta[1] = 32'hDEADBEEF; tb[1] = 32'h01234567; tcin[1] = 1'b1; tsub[1] = 1'b1;
        e = model(ta[1], tb[1], tcin[1], tsub[1]);
        @(negedge clk);
        iv[1] = 1'b0;
        #1;
        n_checks++;
        if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL midrst_early: got %b want 0", ov[1]); end
        @(negedge clk);
        #1;
        n_checks++;
        if (ov[1] !== 1'b1 || {tsum[1], tcout[1], tovf[1]} !== e) begin
            n_fail++; $display("FAIL midrst_next: got %b/%h want 1/%h", ov[1], {tsum[1], tcout[1], tovf[1]}, e);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        exp_t        e;
        bit          ok;
        bit          held [4];
        logic [33:0] hs   [4];
        for (int d = 0; d < 4; d++) begin held[d] = 1'b0; hs[d] = '0; end
        for (int cyc = 0; cyc < 840; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (cyc < 800) begin
                    iv[d]   = ($urandom_range(0, 9) < 7);
                    ordy[d] = ($urandom_range(0, 9) < 7);
                end else begin
                    iv[d]   = 1'b0;
                    ordy[d] = 1'b1;
                end
                ta[d]   = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 32'h7FFFFFFF : 32'h80000000) : $urandom;
                tb[d]   = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 32'hFFFFFFFF : 32'h00000001) : $urandom;
                tcin[d] = 1'($urandom_range(0, 1));
                tsub[d] = 1'($urandom_range(0, 1));
            end
            #1;
            for (int d = 0; d < 4; d++) begin
                if (held[d]) begin
                    n_checks++;
                    if (ov[d] !== 1'b1 || {tsum[d], tcout[d], tovf[d]} !== hs[d]) begin
                        n_fail++; $display("FAIL rand_hold[%0d]@%0d: got %b/%h want 1/%h", d, cyc, ov[d], {tsum[d], tcout[d], tovf[d]}, hs[d]);
                    end
                end
                if (ov[d] && ordy[d]) begin
                    sb_pop(d, e, ok);
                    n_checks++;
                    if (!ok || {tsum[d], tcout[d], tovf[d]} !== e) begin
                        n_fail++; $display("FAIL rand_result[%0d]@%0d: got %h want %h (queued=%0d)", d, cyc, {tsum[d], tcout[d], tovf[d]}, e, ok);
                    end
                end
                if (iv[d] && ir[d]) sb_push(d, model(ta[d], tb[d], tcin[d], tsub[d]));
                held[d] = ov[d] && !ordy[d];
                hs[d]   = {tsum[d], tcout[d], tovf[d]};
            end
        end
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (sb_size(d) != 0) begin n_fail++; $display("FAIL rand_drain[%0d]: got %0d pending want 0", d, sb_size(d)); end
        end
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; ta[d] = '0; tb[d] = '0; tcin[d] = 1'b0; tsub[d] = 1'b0;
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1, "timeout");
    end

endmodule
